// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding, RV32I
// opcodes, opcode classes, pc/wb select encodings and the wait-counter width.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_t;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    typedef enum logic [3:0] {
        ClsR,
        ClsIAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr,
        ClsLui,
        ClsAuipc,
        ClsIllegal
    } op_class_t;

    typedef enum logic [1:0] {
        PcPlus4  = 2'd0,
        PcImm    = 2'd1,
        PcRs1Imm = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2,
        WbImm = 2'd3
    } wb_sel_t;

    function automatic op_class_t decode_class(input logic [6:0] op);
        case (op)
            OpcOp:     return ClsR;
            OpcOpImm:  return ClsIAlu;
            OpcLoad:   return ClsLoad;
            OpcStore:  return ClsStore;
            OpcBranch: return ClsBranch;
            OpcJal:    return ClsJal;
            OpcJalr:   return ClsJalr;
            OpcLui:    return ClsLui;
            OpcAuipc:  return ClsAuipc;
            default:   return ClsIllegal;
        endcase
    endfunction

    // Counter only needs to reach max_wait-1 before timing out.
    function automatic int unsigned cnt_width(input int unsigned max_wait);
        return (max_wait > 1) ? $clog2(max_wait) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles without mem_ready during a memory wait.
// start high clears the count (held high whenever no request is pending);
// timeout is asserted in the MAX_WAIT-th consecutive cycle without ready.
module mem_wait_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned CW = cnt_width(MAX_WAIT);

    logic [CW-1:0] cnt_q;

    assign timeout = !start && !ready && (cnt_q == CW'(MAX_WAIT - 1));

    // Wait counter: cleared outside waits and on every completed request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start || ready) begin
            cnt_q <= '0;
        end else if (!timeout) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Outputs decode the registered state and latched opcode class; the only
// same-cycle input dependencies are mem_ready (ir_we, store pc_we) and br_cond.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to halt on illegal opcodes.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_data,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] pc_sel,
    output logic [1:0] wb_sel,
    output logic       alu_a_pc,
    output logic       alu_b_imm,
    output logic       bus_err,
    output logic       illegal
);

    state_t    state_q;
    op_class_t cls_q;
    op_class_t dec_cls;
    logic      bus_err_q;
    logic      timer_start;
    logic      timeout;

    assign dec_cls     = decode_class(opcode);
    // Count is held clear everywhere except while a memory request is open.
    assign timer_start = !(state_q == StFetch || state_q == StMem);
    assign bus_err     = bus_err_q;

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .ready  (mem_ready),
        .timeout(timeout)
    );

`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // State sequencing, opcode-class latch and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cls_q     <= ClsR;
            bus_err_q <= 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (mem_ready) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q   <= StHalt;
                        bus_err_q <= 1'b1;
                    end
                end
                StDecode: begin
                    cls_q   <= dec_cls;
                    state_q <= StExec;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    if (dec_cls == ClsIllegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
                    end
`endif
                end
                StExec: begin
                    case (cls_q)
                        ClsBranch:         state_q <= StFetch;
                        ClsLoad, ClsStore: state_q <= StMem;
                        default:           state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        state_q <= (cls_q == ClsStore) ? StFetch : StWb;
                    end else if (timeout) begin
                        state_q   <= StHalt;
                        bus_err_q <= 1'b1;
                    end
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode; everything defaults to 0 (IDLE, DECODE, HALT).
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        pc_sel      = PcPlus4;
        wb_sel      = WbAlu;
        alu_a_pc    = 1'b0;
        alu_b_imm   = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            StExec: begin
                alu_a_pc  = cls_q inside {ClsAuipc, ClsJal, ClsBranch};
                alu_b_imm = (cls_q != ClsR);
                if (cls_q == ClsBranch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_cond ? PcImm : PcPlus4;
                end
            end
            StMem: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                mem_we      = (cls_q == ClsStore);
                pc_we       = (cls_q == ClsStore) && mem_ready;
            end
            StWb: begin
                // Illegal ops (trap disabled) retire as a NOP: advance pc only.
                reg_we = (cls_q != ClsIllegal);
                pc_we  = 1'b1;
                case (cls_q)
                    ClsLoad:         wb_sel = WbMem;
                    ClsJal, ClsJalr: wb_sel = WbPc4;
                    ClsLui:          wb_sel = WbImm;
                    default:         wb_sel = WbAlu;
                endcase
                case (cls_q)
                    ClsJal:  pc_sel = PcImm;
                    ClsJalr: pc_sel = PcRs1Imm;
                    default: pc_sel = PcPlus4;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (MAX_WAIT = 4). Inputs change on the
// falling edge and outputs are sampled 1 ns later, mid-cycle.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       br_cond = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_is_data, ir_we, pc_we, reg_we;
    logic [1:0] pc_sel, wb_sel;
    logic       alu_a_pc, alu_b_imm, bus_err, illegal;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .br_cond    (br_cond),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_is_data(mem_is_data),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .pc_sel     (pc_sel),
        .wb_sel     (wb_sel),
        .alu_a_pc   (alu_a_pc),
        .alu_b_imm  (alu_b_imm),
        .bus_err    (bus_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, mem_is_data, ir_we, pc_we, reg_we, pc_sel, wb_sel,
                  alu_a_pc, alu_b_imm, bus_err, illegal};

    // Packs an expected output vector in the same order as obs.
    function automatic logic [13:0] ov(input logic req, we, isd, ir, pcwe, regwe,
                                       input logic [1:0] pcs, wbs,
                                       input logic apc, bimm, berr, ill);
        return {req, we, isd, ir, pcwe, regwe, pcs, wbs, apc, bimm, berr, ill};
    endfunction

    task automatic do_reset(input logic [6:0] op, input logic brc);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = op;
        br_cond = brc;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next_cycle(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = OP_R;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL reset_hold: got %b expected %b", obs, 14'd0); errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL reset_idle: got %b expected %b", obs, 14'd0); errors++;
        end
        next_cycle(1'b0);
        checks++;
        if (obs !== ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)) begin
            $display("FAIL reset_first_fetch: got %b expected %b", obs,
                     ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)); errors++;
        end
    endtask

    task automatic test_rtype();
        logic [13:0] exp [0:4];
        exp[0] = ov(1,0,0,1,0,0,2'd0,2'd0,0,0,0,0);
        exp[1] = 14'd0;
        exp[2] = 14'd0;
        exp[3] = ov(0,0,0,0,1,1,2'd0,2'd0,0,0,0,0);
        exp[4] = ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0);
        do_reset(OP_R, 1'b0);
        for (int i = 0; i < 5; i++) begin
            // mem_ready stays high through DECODE/EXEC/WB and must be ignored
            next_cycle(i < 4);
            checks++;
            if (obs !== exp[i]) begin
                $display("FAIL rtype_cyc%0d: got %b expected %b", i, obs, exp[i]); errors++;
            end
        end
    endtask

    task automatic test_load_wait();
        logic [13:0] exp [0:8];
        logic        rdy [0:8];
        exp[0] = ov(1,0,0,1,0,0,2'd0,2'd0,0,0,0,0); rdy[0] = 1'b1;
        exp[1] = 14'd0;                               rdy[1] = 1'b0;
        exp[2] = ov(0,0,0,0,0,0,2'd0,2'd0,0,1,0,0); rdy[2] = 1'b0;
        exp[3] = ov(1,0,1,0,0,0,2'd0,2'd0,0,0,0,0); rdy[3] = 1'b0;
        exp[4] = exp[3];                              rdy[4] = 1'b0;
        exp[5] = exp[3];                              rdy[5] = 1'b0;
        exp[6] = exp[3];                              rdy[6] = 1'b1;
        exp[7] = ov(0,0,0,0,1,1,2'd0,2'd1,0,0,0,0); rdy[7] = 1'b0;
        exp[8] = ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0); rdy[8] = 1'b0;
        do_reset(OP_LD, 1'b0);
        for (int i = 0; i < 9; i++) begin
            next_cycle(rdy[i]);
            checks++;
            if (obs !== exp[i]) begin
                $display("FAIL load_wait_cyc%0d: got %b expected %b", i, obs, exp[i]); errors++;
            end
        end
    endtask

    task automatic test_store();
        logic [13:0] exp [0:4];
        exp[0] = ov(1,0,0,1,0,0,2'd0,2'd0,0,0,0,0);
        exp[1] = 14'd0;
        exp[2] = ov(0,0,0,0,0,0,2'd0,2'd0,0,1,0,0);
        exp[3] = ov(1,1,1,0,1,0,2'd0,2'd0,0,0,0,0);
        exp[4] = ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0);
        do_reset(OP_ST, 1'b0);
        for (int i = 0; i < 5; i++) begin
            next_cycle(i != 1 && i != 2 && i != 4);
            checks++;
            if (obs !== exp[i]) begin
                $display("FAIL store_cyc%0d: got %b expected %b", i, obs, exp[i]); errors++;
            end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            logic        brc;
            logic [13:0] exp [0:3];
            brc = (k == 0);
            exp[0] = ov(1,0,0,1,0,0,2'd0,2'd0,0,0,0,0);
            exp[1] = 14'd0;
            exp[2] = ov(0,0,0,0,1,0,{1'b0, brc},2'd0,1,1,0,0);
            exp[3] = ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0);
            do_reset(OP_BR, brc);
            for (int i = 0; i < 4; i++) begin
                next_cycle(i == 0);
                checks++;
                if (obs !== exp[i]) begin
                    $display("FAIL branch_br%0d_cyc%0d: got %b expected %b", brc, i, obs, exp[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_classes();
        logic [6:0]  ops [0:4];
        logic [13:0] ex  [0:4];
        logic [13:0] wb  [0:4];
        ops[0] = 7'b0010011; ex[0] = ov(0,0,0,0,0,0,2'd0,2'd0,0,1,0,0);
        wb[0] = ov(0,0,0,0,1,1,2'd0,2'd0,0,0,0,0);
        ops[1] = 7'b0110111; ex[1] = ov(0,0,0,0,0,0,2'd0,2'd0,0,1,0,0);
        wb[1] = ov(0,0,0,0,1,1,2'd0,2'd3,0,0,0,0);
        ops[2] = 7'b0010111; ex[2] = ov(0,0,0,0,0,0,2'd0,2'd0,1,1,0,0);
        wb[2] = ov(0,0,0,0,1,1,2'd0,2'd0,0,0,0,0);
        ops[3] = 7'b1101111; ex[3] = ov(0,0,0,0,0,0,2'd0,2'd0,1,1,0,0);
        wb[3] = ov(0,0,0,0,1,1,2'd1,2'd2,0,0,0,0);
        ops[4] = 7'b1100111; ex[4] = ov(0,0,0,0,0,0,2'd0,2'd0,0,1,0,0);
        wb[4] = ov(0,0,0,0,1,1,2'd2,2'd2,0,0,0,0);
        for (int i = 0; i < 5; i++) begin
            do_reset(ops[i], 1'b0);
            next_cycle(1'b1);
            next_cycle(1'b0);
            next_cycle(1'b0);
            checks++;
            if (obs !== ex[i]) begin
                $display("FAIL class_exec_op%b: got %b expected %b", ops[i], obs, ex[i]); errors++;
            end
            next_cycle(1'b0);
            checks++;
            if (obs !== wb[i]) begin
                $display("FAIL class_wb_op%b: got %b expected %b", ops[i], obs, wb[i]); errors++;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset(OP_BAD, 1'b0);
        next_cycle(1'b1);
        next_cycle(1'b0);
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            next_cycle(1'b1);
            checks++;
            if (obs !== ov(0,0,0,0,0,0,2'd0,2'd0,0,0,0,1)) begin
                $display("FAIL illegal_halt_cyc%0d: got %b expected %b", i, obs,
                         ov(0,0,0,0,0,0,2'd0,2'd0,0,0,0,1)); errors++;
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL illegal_rst_clear: got %b expected %b", obs, 14'd0); errors++;
        end
        @(negedge clk);
        rst = 1'b0;
`else
        next_cycle(1'b0);
        checks++;
        if ({mem_req, pc_we, reg_we, illegal} !== 4'b0000) begin
            $display("FAIL illegal_exec: got %b expected %b", {mem_req, pc_we, reg_we, illegal},
                     4'b0000); errors++;
        end
        next_cycle(1'b0);
        checks++;
        if ({pc_we, reg_we, pc_sel, illegal} !== 5'b10000) begin
            $display("FAIL illegal_nop_wb: got %b expected %b", {pc_we, reg_we, pc_sel, illegal},
                     5'b10000); errors++;
        end
        next_cycle(1'b0);
        checks++;
        if ({mem_req, mem_is_data, illegal} !== 3'b100) begin
            $display("FAIL illegal_refetch: got %b expected %b", {mem_req, mem_is_data, illegal},
                     3'b100); errors++;
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset(OP_R, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b0);
            checks++;
            if (obs !== ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)) begin
                $display("FAIL timeout_fetch_cyc%0d: got %b expected %b", i, obs,
                         ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)); errors++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle(1'b1);
            checks++;
            if (obs !== ov(0,0,0,0,0,0,2'd0,2'd0,0,0,1,0)) begin
                $display("FAIL timeout_halt_cyc%0d: got %b expected %b", i, obs,
                         ov(0,0,0,0,0,0,2'd0,2'd0,0,0,1,0)); errors++;
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL timeout_rst_clear: got %b expected %b", obs, 14'd0); errors++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        do_reset(OP_ST, 1'b0);
        next_cycle(1'b1);
        next_cycle(1'b0);
        next_cycle(1'b0);
        next_cycle(1'b0);
        checks++;
        if (obs !== ov(1,1,1,0,0,0,2'd0,2'd0,0,0,0,0)) begin
            $display("FAIL store_wait: got %b expected %b", obs,
                     ov(1,1,1,0,0,0,2'd0,2'd0,0,0,0,0)); errors++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL rst_mid_store: got %b expected %b", obs, 14'd0); errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 14'd0) begin
            $display("FAIL rst_mid_store_idle: got %b expected %b", obs, 14'd0); errors++;
        end
        next_cycle(1'b0);
        checks++;
        if (obs !== ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)) begin
            $display("FAIL rst_mid_store_refetch: got %b expected %b", obs,
                     ov(1,0,0,0,0,0,2'd0,2'd0,0,0,0,0)); errors++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_classes();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
